// File: rtl/hwag_pkg.sv
// Shared types and widths for the angle generator and its downstream channels.
package hwag_pkg;
  localparam int HWAG_AW = 24;
  localparam int HWAG_DW = 24;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CHARGE  = 2'd2,
    HOLDOFF = 2'd3
  } ign_state_t;
endpackage

// File: rtl/hwag_angle_sub_wrap.sv
// Wrap-around angle subtract: set = ign - d modulo (top+1), d = min(delta, top).
module hwag_angle_sub_wrap #(
  parameter int AW = 24
) (
  input  logic [AW-1:0] ign_i,
  input  logic [AW-1:0] delta_i,
  input  logic [AW-1:0] top_i,
  output logic [AW-1:0] set_o,
  output logic [AW-1:0] d_o
);
  always_comb begin
    d_o = (delta_i > top_i) ? top_i : delta_i;
    // The wrapped result is always below top+1, so the carry bit of the
    // (AW+1)-bit sum is always discarded and AW-bit arithmetic is exact.
    if (d_o > ign_i)
      set_o = ign_i + top_i + AW'(1) - d_o;
    else
      set_o = ign_i - d_o;
  end
endmodule

// File: rtl/hwag_ign_channel.sv
// One ignition coil channel: charges from (spark - delta) to spark angle with
// counter wrap handling and a maximum dwell limit.
module hwag_ign_channel
  import hwag_pkg::*;
#(
  parameter int AW = HWAG_AW,
  parameter int DW = HWAG_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  input  logic          hwag_start,
  input  logic [AW-1:0] acnt,
  input  logic [AW-1:0] acnt_top,
  input  logic [AW-1:0] ign_angle,
  input  logic [AW-1:0] delta_angle,
  input  logic          upd,
  input  logic [DW-1:0] max_dwell,
  output logic          coil_out,
  output logic          spark,
  output logic          dwell_flt,
  output logic          cfg_err
);
  ign_state_t    state_q, state_d;
  logic [AW-1:0] shd_ign_q, shd_ign_d, shd_dlt_q, shd_dlt_d;
  logic [AW-1:0] act_ign_q, act_ign_d, act_dlt_q, act_dlt_d;
  logic [DW-1:0] timer_q, timer_d, timer_inc;
  logic          coil_q, coil_d, spark_q, spark_d, flt_q, flt_d, cfg_q, cfg_d;
  logic [AW-1:0] set_angle, d_clip;
  logic          run, copy, at_ign, bad_ign;

  hwag_angle_sub_wrap #(.AW(AW)) u_wrap (
    .ign_i   (act_ign_q),
    .delta_i (act_dlt_q),
    .top_i   (acnt_top),
    .set_o   (set_angle),
    .d_o     (d_clip)
  );

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    spark_d   = 1'b0;
    flt_d     = 1'b0;
    copy      = 1'b0;
    run       = ena & hwag_start;
    at_ign    = (acnt == act_ign_q);
    bad_ign   = (act_ign_q > acnt_top);
    timer_inc = (timer_q == '1) ? timer_q : timer_q + DW'(1);

    if (!run) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = ARMED;
          copy    = 1'b1;
        end
        ARMED: begin
          if (!bad_ign && d_clip != '0 && acnt == set_angle) begin
            state_d = CHARGE;
            timer_d = '0;
          end
        end
        CHARGE: begin
          // timer_inc counts the current CHARGE cycle, so the coil is held
          // for exactly max_dwell clocks before a forced release.
          timer_d = timer_inc;
          if (at_ign) begin
            state_d = ARMED;
            copy    = 1'b1;
            spark_d = 1'b1;
          end else if (max_dwell != '0 && timer_inc == max_dwell) begin
            state_d = HOLDOFF;
            flt_d   = 1'b1;
          end
        end
        HOLDOFF: begin
          if (at_ign) begin
            state_d = ARMED;
            copy    = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Shadow next-state feeds the copy so an upd on the copy cycle bypasses.
    shd_ign_d = upd ? ign_angle   : shd_ign_q;
    shd_dlt_d = upd ? delta_angle : shd_dlt_q;
    act_ign_d = copy ? shd_ign_d : act_ign_q;
    act_dlt_d = copy ? shd_dlt_d : act_dlt_q;
    cfg_d     = (state_d != IDLE) && (act_ign_d > acnt_top);
    coil_d    = (state_d == CHARGE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      shd_ign_q <= '0;
      shd_dlt_q <= '0;
      act_ign_q <= '0;
      act_dlt_q <= '0;
      timer_q   <= '0;
      coil_q    <= 1'b0;
      spark_q   <= 1'b0;
      flt_q     <= 1'b0;
      cfg_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shd_ign_q <= shd_ign_d;
      shd_dlt_q <= shd_dlt_d;
      act_ign_q <= act_ign_d;
      act_dlt_q <= act_dlt_d;
      timer_q   <= timer_d;
      coil_q    <= coil_d;
      spark_q   <= spark_d;
      flt_q     <= flt_d;
      cfg_q     <= cfg_d;
    end
  end

  assign coil_out  = coil_q;
  assign spark     = spark_q;
  assign dwell_flt = flt_q;
  assign cfg_err   = cfg_q;
endmodule

// File: tb/tb_hwag_ign_channel.sv
// Directed bench for hwag_ign_channel: angle ramps with hand-computed event angles.
module tb_hwag_ign_channel;
  localparam int AW  = 24;
  localparam int DW  = 24;
  localparam int TOP = 719;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ena = 1'b0;
  logic          hwag_start = 1'b0;
  logic          upd = 1'b0;
  logic [AW-1:0] acnt = '0;
  logic [AW-1:0] acnt_top = AW'(TOP);
  logic [AW-1:0] ign_angle = '0;
  logic [AW-1:0] delta_angle = '0;
  logic [DW-1:0] max_dwell = '0;
  logic          coil_out, spark, dwell_flt, cfg_err;

  hwag_ign_channel #(.AW(AW), .DW(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .ena         (ena),
    .hwag_start  (hwag_start),
    .acnt        (acnt),
    .acnt_top    (acnt_top),
    .ign_angle   (ign_angle),
    .delta_angle (delta_angle),
    .upd         (upd),
    .max_dwell   (max_dwell),
    .coil_out    (coil_out),
    .spark       (spark),
    .dwell_flt   (dwell_flt),
    .cfg_err     (cfg_err)
  );

  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_err = 0;
  int   rise_cnt, rise_at, fall_at, spark_cnt, spark_at, first_spark, flt_cnt, high_cnt;
  logic coil_prev = 1'b0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clr();
    rise_cnt = 0; rise_at = -1; fall_at = -1; spark_cnt = 0;
    spark_at = -1; first_spark = -1; flt_cnt = 0; high_cnt = 0;
  endtask

  // One clock with the current inputs; events are tagged with the acnt sampled.
  task automatic cyc();
    int a;
    a = int'(acnt);
    @(posedge clk); #1;
    if (coil_out && !coil_prev) begin rise_cnt++; rise_at = a; end
    if (!coil_out && coil_prev) fall_at = a;
    if (coil_out) high_cnt++;
    if (spark) begin
      spark_cnt++; spark_at = a;
      if (first_spark < 0) first_spark = a;
    end
    if (dwell_flt) flt_cnt++;
    coil_prev = coil_out;
  endtask

  task automatic run(input int from, input int n);
    for (int i = 0; i < n; i++) begin
      acnt = AW'((from + i) % (TOP + 1));
      cyc();
    end
  endtask

  // Drop to IDLE, then re-arm with upd on the arming edge (bypass load).
  task automatic arm(input int ig, input int dl);
    ena = 1'b0; acnt = '0;
    cyc();
    ign_angle = AW'(ig); delta_angle = AW'(dl);
    upd = 1'b1; ena = 1'b1; hwag_start = 1'b1;
    cyc();
    upd = 1'b0;
  endtask

  initial begin
    clr();
    repeat (3) cyc();
    chk("rst_coil",  int'(coil_out),  0);
    chk("rst_spark", int'(spark),     0);
    chk("rst_flt",   int'(dwell_flt), 0);
    chk("rst_cfg",   int'(cfg_err),   0);
    rst = 1'b1;

    // Basic charge window 60..100, repeated each revolution
    arm(100, 40); clr();
    run(0, 720);
    chk("t1_rise", rise_at, 60);
    chk("t1_fall", fall_at, 100);
    chk("t1_spark_n", spark_cnt, 1);
    chk("t1_spark_at", spark_at, 100);
    chk("t1_high", high_cnt, 40);
    clr(); run(0, 720);
    chk("t1_rev2_rise", rise_cnt, 1);
    chk("t1_rev2_spark", spark_cnt, 1);

    // Window across the wrap: set = 10 + 720 - 30 = 700
    arm(10, 30); clr();
    run(0, 740);
    chk("t2_rise", rise_at, 700);
    chk("t2_fall", fall_at, 10);
    chk("t2_spark_n", spark_cnt, 1);
    chk("t2_high", high_cnt, 30);

    // Dwell limit with a stalled counter
    max_dwell = DW'(5);
    arm(100, 40); clr();
    run(0, 61);
    repeat (10) cyc();
    chk("t3_high", high_cnt, 5);
    chk("t3_flt", flt_cnt, 1);
    chk("t3_fall", fall_at, 60);
    clr(); run(61, 659);
    chk("t3_no_spark", spark_cnt, 0);
    clr(); run(0, 61);
    chk("t3_resume", rise_cnt, 1);
    chk("t3_resume_at", rise_at, 60);
    max_dwell = '0;

    // Shadow update during CHARGE, then bypass load on the reload cycle
    arm(100, 40); clr();
    run(0, 80);
    ign_angle = AW'(200); upd = 1'b1; acnt = AW'(80); cyc(); upd = 1'b0;
    run(81, 119);
    chk("t4_first_spark", first_spark, 100);
    chk("t4_rise2", rise_at, 160);
    acnt = AW'(200); ign_angle = AW'(300); delta_angle = AW'(50); upd = 1'b1;
    cyc(); upd = 1'b0;
    run(201, 150);
    chk("t4_rise3", rise_at, 250);
    chk("t4_fall3", fall_at, 300);
    chk("t4_spark_n", spark_cnt, 3);

    // hwag_start drop and reset during CHARGE
    arm(100, 40); clr();
    run(0, 70);
    hwag_start = 1'b0; acnt = AW'(70); cyc();
    chk("t5_drop_coil", int'(coil_out), 0);
    run(71, 40);
    chk("t5_drop_spark", spark_cnt, 0);
    arm(100, 40);
    run(0, 70);
    rst = 1'b0; cyc();
    chk("t5_rst_coil", int'(coil_out), 0);
    chk("t5_rst_spark", int'(spark), 0);
    rst = 1'b1;

    // Full-revolution charge, delta clamped to top: set = 101
    arm(100, 1000); clr();
    run(0, 720); run(0, 101);
    chk("t6_rise", rise_at, 101);
    chk("t6_fall", fall_at, 100);
    chk("t6_spark_n", spark_cnt, 1);
    chk("t6_high", high_cnt, 719);

    // Invalid spark angle, then zero delta
    arm(800, 40); clr();
    chk("t7_cfg_set", int'(cfg_err), 1);
    run(0, 720);
    chk("t7_no_rise", rise_cnt, 0);
    chk("t7_cfg_hold", int'(cfg_err), 1);
    arm(100, 0); clr();
    chk("t7_cfg_clr", int'(cfg_err), 0);
    run(0, 720);
    chk("t7_d0_rise", rise_cnt, 0);
    chk("t7_d0_spark", spark_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
